// File: rtl/vital_alarm_manager.sv
// vital_alarm_manager: per-channel persisted range alarms with ack, escalation and priority report
module vital_alarm_manager #(
  parameter int N_CH = 3,
  parameter int W = 8,
  parameter int PERSIST = 3,
  parameter int CLEAR = 2,
  parameter int ESCALATE_CYCLES = 10,
  parameter int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   sample_valid,
  input  logic [N_CH*W-1:0] sample_data,
  input  logic [N_CH*W-1:0] lo_thresh,
  input  logic [N_CH*W-1:0] hi_thresh,
  input  logic [N_CH-1:0]   ack,
  output logic [N_CH-1:0]   alarm,
  output logic [N_CH-1:0]   escalate,
  output logic [N_CH-1:0]   fault_high,
  output logic [N_CH-1:0]   in_fault,
  output logic              any_alarm,
  output logic              top_valid,
  output logic [CHW-1:0]    top_ch
);
  localparam logic [1:0] NORMAL = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] ALARM = 2'd2;
  localparam logic [1:0] ACKED = 2'd3;
  localparam int MX = (PERSIST > CLEAR) ? PERSIST : CLEAR;
  localparam int CW = $clog2(MX + 1);
  localparam int TW = $clog2(ESCALATE_CYCLES + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PERSIST - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLEAR - 1);
  localparam logic [TW-1:0] T_MAX = TW'(ESCALATE_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(ESCALATE_CYCLES - 1);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0] st;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmr;
    logic esc, fh;
    logic [W-1:0] s, lo, hi;
    logic hi_out, out, v;
    assign s = sample_data[i*W +: W];
    assign lo = lo_thresh[i*W +: W];
    assign hi = hi_thresh[i*W +: W];
    assign hi_out = s > hi;
    assign out = (s < lo) | hi_out;
    assign v = sample_valid[i];
    always_ff @(posedge clk) begin
      if (reset) begin
        st <= NORMAL;
        cnt <= '0;
        tmr <= '0;
        esc <= 1'b0;
        fh <= 1'b0;
      end else begin
        case (st)
          NORMAL: if (v && out) begin
            cnt <= CW'(1);
            fh <= hi_out;
            tmr <= '0;
            st <= (PERSIST == 1) ? ALARM : PENDING;
          end
          PENDING: if (v) begin
            if (out) begin
              cnt <= cnt + CW'(1);
              fh <= hi_out;
              tmr <= '0;
              if (cnt == P_LAST) st <= ALARM;
            end else begin
              cnt <= '0;
              st <= NORMAL;
            end
          end
          ALARM: if (ack[i]) begin
            st <= ACKED;
            cnt <= '0;
            esc <= 1'b0;
          end else begin
            // timer runs per clock and saturates so escalate holds until ack
            tmr <= (tmr == T_MAX) ? tmr : tmr + TW'(1);
            if (tmr >= T_LAST) esc <= 1'b1;
          end
          ACKED: if (v) begin
            cnt <= (out || cnt == C_LAST) ? '0 : cnt + CW'(1);
            if (!out && cnt == C_LAST) st <= NORMAL;
          end
          default: st <= NORMAL;
        endcase
      end
    end
    assign alarm[i] = st == ALARM;
    assign in_fault[i] = st[1];
    assign escalate[i] = esc;
    assign fault_high[i] = fh;
  end
  assign any_alarm = |alarm;
  assign top_valid = any_alarm;
  always_comb begin
    top_ch = '0;
    for (int k = N_CH - 1; k >= 0; k--) if (alarm[k]) top_ch = CHW'(k);
  end
endmodule

// File: tb/tb_vital_alarm_manager.sv
// tb_vital_alarm_manager: directed scoreboard bench for vital_alarm_manager
module tb_vital_alarm_manager;
  localparam int N = 3;
  localparam int W = 8;
  localparam int SA = 0, SE = 1, SF = 2, SI = 3, SANY = 4, STV = 5, STC = 6;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] sample_valid = '0;
  logic [N-1:0] ack = '0;
  logic [N*W-1:0] sample_data = '0;
  logic [N*W-1:0] lo_thresh, hi_thresh;
  logic [N-1:0] alarm, escalate, fault_high, in_fault;
  logic any_alarm, top_valid;
  logic [1:0] top_ch;
  typedef struct {
    string tag;
    int sig;
    logic [7:0] mask;
    logic [7:0] val;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int gl[5] = '{50, 50, 70, 50, 50};
  int bd[6] = '{110, 110, 60, 110, 110, 100};

  vital_alarm_manager dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .lo_thresh(lo_thresh), .hi_thresh(hi_thresh), .ack(ack), .alarm(alarm),
    .escalate(escalate), .fault_high(fault_high), .in_fault(in_fault),
    .any_alarm(any_alarm), .top_valid(top_valid), .top_ch(top_ch)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs(int sig);
    case (sig)
      SA: obs = {5'd0, alarm};
      SE: obs = {5'd0, escalate};
      SF: obs = {5'd0, fault_high};
      SI: obs = {5'd0, in_fault};
      SANY: obs = {7'd0, any_alarm};
      STV: obs = {7'd0, top_valid};
      default: obs = {6'd0, top_ch};
    endcase
  endfunction

  task automatic push(string tag, int sig, logic [7:0] mask, logic [7:0] val);
    q.push_back('{tag, sig, mask, val});
  endtask

  task automatic tick;
    exp_t e;
    @(posedge clk);
    #1;
    sample_valid = '0;
    ack = '0;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert ((obs(e.sig) & e.mask) === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs(e.sig) & e.mask, e.val);
      end
    end
  endtask

  task automatic smp(int ch, int v);
    sample_valid[ch] = 1'b1;
    sample_data[ch*W +: W] = W'(v);
  endtask

  task automatic s1(int ch, int v, string tag, logic [7:0] a);
    smp(ch, v);
    push(tag, SA, 8'hff, a);
    tick;
  endtask

  initial begin
    lo_thresh = {8'd10, 8'd97, 8'd60};
    hi_thresh = {8'd17, 8'd100, 8'd100};
    for (int s = 0; s < 7; s++) push("reset", s, 8'hff, 8'h00);
    tick;
    reset = 1'b0;
    s1(0, 110, "persist1", 8'h0);
    s1(0, 110, "persist2", 8'h0);
    smp(0, 110);
    push("persist_alarm", SA, 8'hff, 8'h1);
    push("persist_fh", SF, 8'h1, 8'h1);
    push("persist_top", STC, 8'hff, 8'h0);
    push("persist_any", SANY, 8'hff, 8'h1);
    push("persist_tv", STV, 8'hff, 8'h1);
    tick;
    ack[0] = 1'b1;
    push("ack0_alarm", SA, 8'hff, 8'h0);
    push("ack0_infault", SI, 8'hff, 8'h1);
    tick;
    s1(0, 80, "clr0_first", 8'h0);
    smp(0, 80);
    push("clr0_done", SI, 8'hff, 8'h0);
    tick;
    for (int k = 0; k < 5; k++) s1(0, gl[k], "glitch", 8'h0);
    smp(0, 50);
    push("glitch_alarm", SA, 8'hff, 8'h1);
    push("glitch_fh_low", SF, 8'h1, 8'h0);
    tick;
    ack[0] = 1'b1;
    tick;
    s1(0, 60, "bnd_eq_lo", 8'h0);
    smp(0, 100);
    push("bnd_eq_hi_clear", SI, 8'hff, 8'h0);
    tick;
    for (int k = 0; k < 6; k++) s1(0, bd[k], "bnd_seq", 8'h0);
    s1(1, 96, "esc_p1", 8'h0);
    s1(1, 96, "esc_p2", 8'h0);
    smp(1, 96);
    push("esc_alarm", SA, 8'hff, 8'h2);
    push("esc_fh_low", SF, 8'h2, 8'h0);
    tick;
    for (int k = 0; k < 9; k++) begin
      push("esc_early", SE, 8'hff, 8'h0);
      tick;
    end
    push("esc_rise", SE, 8'hff, 8'h2);
    push("esc_alarm_held", SA, 8'hff, 8'h2);
    tick;
    ack[1] = 1'b1;
    push("esc_ack_alarm", SA, 8'hff, 8'h0);
    push("esc_ack_esc", SE, 8'hff, 8'h0);
    push("esc_ack_infault", SI, 8'hff, 8'h2);
    tick;
    smp(1, 98);
    tick;
    smp(1, 98);
    push("esc_clear", SI, 8'hff, 8'h0);
    tick;
    s1(1, 96, "col_p1", 8'h0);
    s1(1, 96, "col_p2", 8'h0);
    smp(1, 96);
    push("col_alarm", SA, 8'hff, 8'h2);
    tick;
    for (int k = 0; k < 9; k++) begin
      push("col_early", SE, 8'hff, 8'h0);
      tick;
    end
    ack[1] = 1'b1;
    push("col_esc", SE, 8'hff, 8'h0);
    push("col_alarm_off", SA, 8'hff, 8'h0);
    push("col_acked", SI, 8'hff, 8'h2);
    tick;
    for (int k = 0; k < 3; k++) begin
      push("col_esc_after", SE, 8'hff, 8'h0);
      tick;
    end
    smp(1, 98);
    tick;
    smp(1, 98);
    push("col_clear", SI, 8'hff, 8'h0);
    tick;
    s1(2, 5, "clr_p1", 8'h0);
    s1(2, 5, "clr_p2", 8'h0);
    smp(2, 5);
    push("clr_alarm", SA, 8'hff, 8'h4);
    push("clr_fh_low", SF, 8'h4, 8'h0);
    tick;
    ack[2] = 1'b1;
    push("clr_ack", SA, 8'hff, 8'h0);
    push("clr_acked", SI, 8'hff, 8'h4);
    tick;
    smp(2, 12);
    push("clr_12a", SI, 8'hff, 8'h4);
    tick;
    smp(2, 20);
    push("clr_20", SI, 8'hff, 8'h4);
    push("clr_no_realarm", SA, 8'hff, 8'h0);
    tick;
    smp(2, 12);
    push("clr_12b", SI, 8'hff, 8'h4);
    tick;
    smp(2, 12);
    push("clr_done", SI, 8'hff, 8'h0);
    tick;
    s1(2, 20, "pri_p1", 8'h0);
    s1(2, 20, "pri_p2", 8'h0);
    smp(2, 20);
    push("pri_alarm2", SA, 8'hff, 8'h4);
    push("pri_top2", STC, 8'hff, 8'h2);
    push("pri_fh_high", SF, 8'h4, 8'h4);
    tick;
    s1(1, 96, "pri_q1", 8'h4);
    s1(1, 96, "pri_q2", 8'h4);
    smp(1, 96);
    push("pri_alarm12", SA, 8'hff, 8'h6);
    push("pri_top1", STC, 8'hff, 8'h1);
    push("pri_tv", STV, 8'hff, 8'h1);
    tick;
    reset = 1'b1;
    ack[1] = 1'b1;
    smp(0, 110);
    for (int s = 0; s < 7; s++) push("mid_reset", s, 8'hff, 8'h00);
    tick;
    reset = 1'b0;
    smp(0, 110);
    push("post_reset_alarm", SA, 8'hff, 8'h0);
    push("post_reset_infault", SI, 8'hff, 8'h0);
    tick;
    s1(0, 110, "post_reset_p2", 8'h0);
    smp(0, 110);
    push("post_reset_alarm3", SA, 8'hff, 8'h1);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vital_alarm_manager.md
Name: vital_alarm_manager

Overview:
- Parametrised, multi-channel successor to the fixed single-purpose BPM and temperature range checkers.
- Each of N_CH channels compares strobed vital-sign samples against runtime low/high thresholds.
- An alarm is raised only after PERSIST consecutive out-of-range samples. It stays latched until acknowledged and escalates if left unacknowledged. It returns to normal only after CLEAR consecutive in-range samples.
- Sits between sensor front-ends and the control/annunciation logic; also reports the highest-priority (lowest-index) alarming channel.

Parameters:
- N_CH, 3, number of monitored channels (1..16).
- W, 8, sample and threshold width in bits (unsigned).
- PERSIST, 3, consecutive out-of-range samples required to raise an alarm (>=1).
- CLEAR, 2, consecutive in-range samples required after ack to return to NORMAL (>=1).
- ESCALATE_CYCLES, 10, clock cycles in ALARM without ack before escalate asserts (>=1).
- CHW, $clog2(N_CH) (min 1), width of top_ch.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  N_CH  per-channel one-cycle sample strobe.
- sample_data  in  N_CH*W  channel i occupies bits [i*W +: W].
- lo_thresh  in  N_CH*W  per-channel low limit, same packing.
- hi_thresh  in  N_CH*W  per-channel high limit, same packing.
- ack  in  N_CH  per-channel acknowledge pulse.
- alarm  out  N_CH  channel is in ALARM state.
- escalate  out  N_CH  alarm unacknowledged for ESCALATE_CYCLES.
- fault_high  out  N_CH  direction of the latched fault: 1 = above hi, 0 = below lo.
- in_fault  out  N_CH  channel is in ALARM or ACKED.
- any_alarm  out  1  OR of alarm.
- top_valid  out  1  equals any_alarm.
- top_ch  out  CHW  lowest index with alarm=1; 0 when none.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
  - reset=1 at an edge puts every channel in NORMAL and clears all counters and timers.
  - All outputs are 0 after that edge.
  - reset overrides every other input in the same cycle, including mid-alarm.
- Range check: out = (sample < lo) | (sample > hi), unsigned. Equality with either limit is in range.
  - If lo > hi, every sample is out of range. This is legal and not flagged.
  - dir_high = (sample > hi). When both conditions hold (lo > hi case), dir_high = 1.
- Thresholds are sampled only in cycles where sample_valid[i]=1. Changing them mid-stream takes effect on the next valid sample.
- Channels are fully independent; no input from one channel affects another's state.
- Per-channel FSM, states NORMAL, PENDING, ALARM, ACKED; cnt is the persist/clear counter; tmr is the escalation timer.
  - NORMAL, valid & out: cnt=1 and fault_high=dir_high.
    - If PERSIST==1, go to ALARM.
    - Otherwise go to PENDING.
  - PENDING, valid & out: cnt++ and fault_high=dir_high (tracks the latest sample).
    - When cnt reaches PERSIST, go to ALARM.
  - PENDING, valid & in-range: cnt=0, go to NORMAL.
  - ALARM on entry: tmr=0; tmr increments every clock, not per sample.
    - fault_high is frozen; samples are ignored.
    - ack[i]=1: go to ACKED and clear escalate.
    - When tmr reaches ESCALATE_CYCLES: escalate=1 until ack or reset. tmr saturates.
    - ack and escalation threshold in the same cycle: ack wins and escalate stays 0.
  - ACKED on entry: cnt=0.
    - valid & in-range: cnt++; at CLEAR, go to NORMAL.
    - valid & out: cnt=0, stay in ACKED, no re-alarm, fault_high frozen.
    - ack is ignored.
  - ack in NORMAL or PENDING is ignored.
  - Cycles with no valid sample leave cnt unchanged in every state.
- Latency:
  - The edge that accepts the PERSIST-th out-of-range sample makes alarm=1 in the following cycle.
  - escalate rises exactly ESCALATE_CYCLES clocks after alarm rises, if no ack arrives.
  - alarm falls in the cycle after the edge that samples ack.
  - in_fault falls in the cycle after the edge that accepts the CLEAR-th in-range sample.
- Priority outputs: top_ch, top_valid and any_alarm are combinational from the registered alarm vector, so they add zero extra latency.
- Counter widths: cnt is $clog2(max(PERSIST,CLEAR)+1) bits. tmr is $clog2(ESCALATE_CYCLES+1) bits. Neither may wrap.

Test Plan (defaults; ch0 lo=60 hi=100, ch1 lo=97 hi=100, ch2 lo=10 hi=17):
- Persist: ch0 valid samples 110, 110, 110 on consecutive cycles.
  - Required: alarm[0]=1 and fault_high[0]=1 one cycle after the third sample.
  - Required: top_ch=0, any_alarm=1.
- Glitch rejection: ch0 samples 50, 50, 70, 50, 50.
  - Required: alarm stays 0.
  - Required: the third 50 (following the two at the end of the sequence) raises alarm with fault_high=0.
  - Boundary: samples of exactly 60 and 100 never count as out of range.
- Escalation: raise alarm on ch1 (96 ×3) with no ack.
  - Required: escalate[1]=1 exactly 10 cycles after alarm[1] rose.
  - ack[1] then clears both alarm[1] and escalate[1]; in_fault[1] stays 1.
- Ack/escalate collision: ack[1] asserted in the cycle tmr reaches 10.
  - Required: escalate[1] never asserts; state becomes ACKED.
- Clear: in ACKED on ch2, send samples 12, 20, 12, 12.
  - Required: in_fault[2] falls only after the final 12; the 20 resets the clear count.
  - Required: no re-alarm occurs on the 20.
- Priority and reset: alarms on ch2, then ch1.
  - Required: top_ch=2, then 1.
  - Assert reset mid-ALARM: all outputs 0 the next cycle; a subsequent single out-of-range sample gives PENDING only (alarm=0).
